// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM among N_REQ readers; fixed 2-cycle read latency, fully pipelined.
// enable only gates new grants (in-flight reads complete); define SPRITE_ARB_FIXED_PRI_EN for lowest-index-wins priority.
module sprite_rom_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                    vga_clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        gnt,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [DATA_W-1:0]       rom_q,
    output logic [DATA_W-1:0]       rdata,
    output logic                    rvalid,
    output logic [ID_W-1:0]         rid
);

    logic              win_vld;
    logic [ID_W-1:0]   win_idx;
    logic [ADDR_W-1:0] rom_addr_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              v1_q;
    logic [ID_W-1:0]   id1_q;
    logic              rvalid_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;

`ifdef SPRITE_ARB_FIXED_PRI_EN
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        // Descending scan so the lowest requesting index is the last (winning) assignment.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win_vld = 1'b1;
                win_idx = ID_W'(i);
            end
        end
        if (!enable || !reset_n) begin
            win_vld = 1'b0;
        end
    end
`else
    logic [ID_W-1:0] last_gnt_q;

    always_comb begin
        int cand;
        cand    = 0;
        win_vld = 1'b0;
        win_idx = '0;
        // Scan offsets from N_REQ down to 1 so the nearest index after last_gnt wins.
        for (int k = N_REQ; k >= 1; k--) begin
            cand = (int'(last_gnt_q) + k) % N_REQ;
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = ID_W'(cand);
            end
        end
        if (!enable || !reset_n) begin
            win_vld = 1'b0;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_q <= ID_W'(N_REQ - 1);
        end else if (win_vld) begin
            last_gnt_q <= win_idx;
        end
    end
`endif

    always_comb begin
        gnt        = '0;
        rom_addr_d = rom_addr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_vld && (win_idx == ID_W'(i))) begin
                gnt[i]     = 1'b1;
                rom_addr_d = addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Stage 1 tracks the read whose address is at the ROM; stage 2 captures the ROM word.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr_q <= '0;
            v1_q       <= 1'b0;
            id1_q      <= '0;
            rvalid_q   <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            v1_q       <= win_vld;
            if (win_vld) begin
                id1_q <= win_idx;
            end
            rvalid_q <= v1_q;
            if (v1_q) begin
                rdata_q <= rom_q;
                rid_q   <= id1_q;
            end
        end
    end

    assign rom_addr = rom_addr_q;
    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign rid      = rid_q;

endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters; legal range 2..8.
REQ-002 SHALL have parameter ADDR_W, default 7: ROM address width.
REQ-003 SHALL have parameter DATA_W, default 4: ROM word width, which is a palette index.
REQ-004 SHALL have port vga_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: when low, no new grants are issued.
REQ-007 SHALL have port req, input, N_REQ bits: per-requester read request, held until granted.
REQ-008 SHALL have port addr, input, N_REQ*ADDR_W bits: per-requester address, with slice i at [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port gnt, output, N_REQ bits: one-hot or zero; combinational grant in the request cycle.
REQ-010 SHALL have port rom_addr, output, ADDR_W bits: registered address to the shared ROM.
REQ-011 SHALL have port rom_q, input, DATA_W bits: ROM data, valid in the cycle after rom_addr changes (the ROM is clocked on the inverted vga_clk).
REQ-012 SHALL have port rdata, output, DATA_W bits: registered returned data.
REQ-013 SHALL have port rvalid, output, 1 bit: rdata is valid this cycle.
REQ-014 SHALL have port rid, output, $clog2(N_REQ) bits: index of the requester that owns rdata.

Function
REQ-015 SHALL grant at most one requester per cycle: gnt[i]=1 only if req[i]=1 and enable=1.
REQ-016 SHALL use round-robin arbitration: the search starts at (last_gnt+1) mod N_REQ and picks the first set req bit; last_gnt updates only on a cycle with a grant.
REQ-017 SHALL wrap the search past index N_REQ-1 to index 0.
REQ-018 SHALL, on the rising edge ending grant cycle T, register rom_addr = addr slice of the winner; with no grant, rom_addr holds its value.
REQ-019 SHALL, on the edge ending T+1, register rdata=rom_q, rvalid=1 and rid=winner; rdata/rvalid/rid are visible in cycle T+2, a fixed latency of 2.
REQ-020 SHALL be fully pipelined: grants may issue every cycle and up to 2 reads may be in flight.
REQ-021 SHALL assert rvalid for exactly 1 cycle per grant, returning data in grant order.
REQ-022 SHALL, when enable falls, still complete in-flight reads; it only blocks new grants.
REQ-023 SHALL, in cycles with no grant two cycles earlier, drive rvalid=0 and hold rdata and rid.
REQ-024 SHALL depend on the requester protocol: a requester drops req (or presents a new address) in the cycle after it sees gnt; a req held high is treated as a new request.
REQ-025 SHALL return valid data for any address; no range check is performed on addresses.
REQ-026 SHALL contain internal state consisting only of: the last_gnt pointer, a 2-stage valid/id pipeline, rom_addr and rdata.

Reset
REQ-027 SHALL, while reset_n=0, force gnt=0, rom_addr=0, rdata=0, rvalid=0, rid=0 and last_gnt=N_REQ-1, so requester 0 has first priority after reset.
REQ-028 SHALL, on reset asserted mid-operation, squash all in-flight reads: no rvalid is produced for them after release.
REQ-029 SHALL be able to grant in the first cycle after reset_n deasserts.

Configuration
REQ-030 SHALL, with macro SPRITE_ARB_FIXED_PRI_EN defined, use fixed priority instead of round-robin: the lowest set index wins, and last_gnt is not implemented.
REQ-031 SHALL, without SPRITE_ARB_FIXED_PRI_EN, use round-robin per REQ-016; the interface and latency are identical in both builds.

Verification
REQ-032 SHALL verify single read: after reset, req=4'b0001 with addr0=7'd37, 1 cycle, ROM model q=addr[3:0] -> gnt=4'b0001 in T; rvalid=1, rid=0, rdata=4'h5 in T+2.
REQ-033 SHALL verify round-robin with all requesters continuously requesting: req=4'b1111 held for 8 cycles -> gnt sequence 0,1,2,3,0,1,2,3; rvalid high T+2..T+9 with rid in the same order.
REQ-034 SHALL verify wrap and skip: last_gnt=3, req=4'b0100 -> gnt=4'b0100; then req=4'b0011 -> gnt=4'b0001.
REQ-035 SHALL verify enable gating: req=4'b0010 with enable=0 for 3 cycles -> gnt=0 and rvalid=0; enable=1 -> gnt=4'b0010 that cycle, rvalid 2 cycles later.
REQ-036 SHALL verify reset mid-flight: grants in T and T+1, reset_n=0 pulsed during T+1 -> rvalid stays 0 through T+4; the next grant goes to the lowest requesting index.
REQ-037 SHALL verify fixed-priority build (SPRITE_ARB_FIXED_PRI_EN): req=4'b1010 held for 4 cycles -> gnt=4'b0010 every cycle; requester 3 is never granted.
